// File: rtl/hpm_counter_bank.sv
// Machine-mode performance counter bank: mcycle, minstret, NUM_HPM event counters,
// inhibit, event selectors and sticky overflow with interrupt request.
module hpm_counter_bank #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  retire,
    input  logic                  csr_en,
    input  logic [11:0]           csr_addr,
    input  logic [1:0]            csr_op,
    input  logic [31:0]           csr_wdata,
    output logic [31:0]           csr_rdata,
    output logic                  csr_hit,
    output logic                  ovf_irq
);
    localparam logic [31:0] HPM_MASK = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);
    localparam logic [31:0] INH_MASK = HPM_MASK | 32'h0000_0005;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] mcycle_reg;
    logic [CNT_WIDTH-1:0] minstret_reg;
    logic [31:0]          inhibit_reg;
    logic [31:0]          ovf_reg;
    logic [31:0]          ovfen_reg;

    logic [CNT_WIDTH-1:0] hpm_cnt [NUM_HPM];
    logic [7:0]           hpm_sel [NUM_HPM];
    logic [NUM_HPM-1:0]   hpm_ovf_set;
    logic [31:0]          ovf_set;

    logic [63:0]  cnt_view [32];
    logic [7:0]   sel_view [32];
    logic [255:0] event_pad;

    logic [6:0]  region;
    logic [4:0]  idx;
    logic        sel_cnt_lo, sel_cnt_hi, sel_inh, sel_evt, sel_ovf, sel_ovfen;
    logic        owned;
    logic        wr_en, wr_lo, wr_hi;
    logic [31:0] cur_val;
    logic [31:0] new_val;

    // Selector value k looks at event_in[k-1]; 0 and out-of-range selectors hit zero padding.
    always_comb begin
        event_pad = '0;
        event_pad[NUM_EVENTS:1] = event_in;
    end

    assign region     = csr_addr[11:5];
    assign idx        = csr_addr[4:0];
    assign sel_cnt_lo = (region == 7'h58) && (idx != 5'd1);
    assign sel_cnt_hi = (region == 7'h5C) && (idx != 5'd1);
    assign sel_inh    = (csr_addr == 12'h320);
    assign sel_evt    = (region == 7'h19) && (idx >= 5'd3);
    assign sel_ovf    = (csr_addr == 12'h7C0);
    assign sel_ovfen  = (csr_addr == 12'h7C1);
    assign owned      = sel_cnt_lo | sel_cnt_hi | sel_inh | sel_evt | sel_ovf | sel_ovfen;

    // Flat 32-entry views indexed directly by the low address bits; unimplemented slots stay 0.
    always_comb begin
        for (int k = 0; k < 32; k++) begin
            cnt_view[k] = '0;
            sel_view[k] = '0;
        end
        cnt_view[0] = 64'(mcycle_reg);
        cnt_view[2] = 64'(minstret_reg);
        for (int k = 0; k < NUM_HPM; k++) begin
            cnt_view[k+3] = 64'(hpm_cnt[k]);
            sel_view[k+3] = hpm_sel[k];
        end
    end

    always_comb begin
        cur_val = '0;
        if (sel_cnt_lo)
            cur_val = cnt_view[idx][31:0];
        else if (sel_cnt_hi)
            cur_val = cnt_view[idx][63:32];
        else if (sel_inh)
            cur_val = inhibit_reg;
        else if (sel_evt)
            cur_val = {24'd0, sel_view[idx]};
        else if (sel_ovf)
            cur_val = ovf_reg;
        else if (sel_ovfen)
            cur_val = ovfen_reg;
    end

    always_comb begin
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = cur_val | csr_wdata;
            2'b11:   new_val = cur_val & ~csr_wdata;
            default: new_val = cur_val;
        endcase
    end

    assign wr_en = csr_en && owned && (csr_op != 2'b00);
    assign wr_lo = wr_en && sel_cnt_lo;
    assign wr_hi = wr_en && sel_cnt_hi;

    // A CSR write to either half takes priority over the increment in the same cycle.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 lo,
        input logic                 hi,
        input logic                 inc,
        input logic [31:0]          nv
    );
        if (lo)
            return {cur[CNT_WIDTH-1:32], nv};
        else if (hi)
            return {nv[CNT_WIDTH-33:0], cur[31:0]};
        else if (inc)
            return cur + CNT_ONE;
        return cur;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            mcycle_reg   <= cnt_next(mcycle_reg, wr_lo && (idx == 5'd0), wr_hi && (idx == 5'd0),
                                     !inhibit_reg[0], new_val);
            minstret_reg <= cnt_next(minstret_reg, wr_lo && (idx == 5'd2), wr_hi && (idx == 5'd2),
                                     retire && !inhibit_reg[2], new_val);
        end
    end

    for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
        localparam logic [4:0] IDX = 5'(gi + 3);
        logic [CNT_WIDTH-1:0] cnt_reg;
        logic [7:0]           sel_reg;
        logic                 hit_lo, hit_hi, inc;

        assign hit_lo = wr_lo && (idx == IDX);
        assign hit_hi = wr_hi && (idx == IDX);
        assign inc    = !inhibit_reg[gi+3] && event_pad[sel_reg];
        assign hpm_ovf_set[gi] = inc && !hit_lo && !hit_hi && (cnt_reg == CNT_MAX);

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
                sel_reg <= '0;
            end else begin
                cnt_reg <= cnt_next(cnt_reg, hit_lo, hit_hi, inc, new_val);
                if (wr_en && sel_evt && (idx == IDX))
                    sel_reg <= new_val[7:0];
            end
        end

        assign hpm_cnt[gi] = cnt_reg;
        assign hpm_sel[gi] = sel_reg;
    end

    always_comb begin
        ovf_set = '0;
        ovf_set[3 +: NUM_HPM] = hpm_ovf_set;
    end

    // Hardware overflow set is OR-ed after the CSR write so it wins a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            inhibit_reg <= '0;
            ovf_reg     <= '0;
            ovfen_reg   <= '0;
        end else begin
            if (wr_en && sel_inh)
                inhibit_reg <= new_val & INH_MASK;
            if (wr_en && sel_ovfen)
                ovfen_reg <= new_val & HPM_MASK;
            ovf_reg <= ((wr_en && sel_ovf) ? (new_val & HPM_MASK) : ovf_reg) | ovf_set;
        end
    end

    assign csr_hit   = !rst && csr_en && owned;
    assign csr_rdata = csr_hit ? cur_val : 32'd0;
    assign ovf_irq   = !rst && (|(ovf_reg & ovfen_reg));

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Bench for hpm_counter_bank: directed scenarios then random CSR traffic,
// all checked against an architectural model of the counter CSRs.
module tb_hpm_counter_bank;
    localparam int NH = 4;
    localparam int CW = 40;
    localparam int NE = 8;
    localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

    logic          clk = 1'b0;
    logic          rst;
    logic [NE-1:0] event_in;
    logic          retire;
    logic          csr_en;
    logic [11:0]   csr_addr;
    logic [1:0]    csr_op;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          csr_hit;
    logic          ovf_irq;

    int checks = 0;
    int errors = 0;

    // Architectural model: counter values by CSR index, selectors, inhibit/ovf/ovfen words.
    longint unsigned cnt_m [32];
    logic [7:0]      evt_m [32];
    logic [31:0]     inh_m, ovf_m, ovfen_m;

    logic [31:0] obs_rdata;
    logic        obs_hit, obs_irq;

    hpm_counter_bank #(.NUM_HPM(NH), .CNT_WIDTH(CW), .NUM_EVENTS(NE)) dut (
        .clk(clk), .rst(rst), .event_in(event_in), .retire(retire),
        .csr_en(csr_en), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_hit(csr_hit), .ovf_irq(ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit impl_cnt(input int k);
        return (k == 0) || (k == 2) || (k >= 3 && k < 3 + NH);
    endfunction

    function automatic bit impl_hpm(input int k);
        return (k >= 3 && k < 3 + NH);
    endfunction

    // Returns {owned, value}.
    function automatic logic [32:0] model_read(input logic [11:0] a);
        int k;
        k = int'(a[4:0]);
        if (a >= 12'hB00 && a <= 12'hB1F && k != 1)
            return {1'b1, impl_cnt(k) ? cnt_m[k][31:0] : 32'd0};
        if (a >= 12'hB80 && a <= 12'hB9F && k != 1)
            return {1'b1, impl_cnt(k) ? cnt_m[k][63:32] : 32'd0};
        if (a == 12'h320) return {1'b1, inh_m};
        if (a >= 12'h323 && a <= 12'h33F)
            return {1'b1, impl_hpm(k) ? {24'd0, evt_m[k]} : 32'd0};
        if (a == 12'h7C0) return {1'b1, ovf_m};
        if (a == 12'h7C1) return {1'b1, ovfen_m};
        return 33'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            cnt_m[k] = 0;
            evt_m[k] = 8'd0;
        end
        inh_m = '0;
        ovf_m = '0;
        ovfen_m = '0;
    endtask

    task automatic model_step(input logic r, input logic en, input logic [11:0] a,
                              input logic [1:0] op, input logic [31:0] wd,
                              input logic ret, input logic [7:0] ev);
        longint unsigned nxt [32];
        logic [31:0] setb, ovf_n, cur, nv, hmask;
        logic [32:0] m;
        int k;
        if (r) begin
            model_reset();
            return;
        end
        hmask = '0;
        for (int j = 3; j < 3 + NH; j++) hmask[j] = 1'b1;
        nxt   = cnt_m;
        setb  = '0;
        ovf_n = ovf_m;
        if (!inh_m[0]) nxt[0] = (cnt_m[0] + 1) & CMASK;
        if (ret && !inh_m[2]) nxt[2] = (cnt_m[2] + 1) & CMASK;
        for (int i = 0; i < NH; i++) begin
            int s;
            s = int'(evt_m[3+i]);
            if (!inh_m[3+i] && s >= 1 && s <= NE && ev[s-1]) begin
                if (cnt_m[3+i] == CMASK) setb[3+i] = 1'b1;
                nxt[3+i] = (cnt_m[3+i] + 1) & CMASK;
            end
        end
        m = model_read(a);
        if (en && op != 2'b00 && m[32]) begin
            cur = m[31:0];
            nv  = (op == 2'b01) ? wd : (op == 2'b10) ? (cur | wd) : (cur & ~wd);
            k   = int'(a[4:0]);
            if (a[11:5] == 7'h58 && impl_cnt(k)) begin
                nxt[k]  = (cnt_m[k] & ~64'hFFFF_FFFF) | 64'(nv);
                setb[k] = 1'b0;
            end else if (a[11:5] == 7'h5C && impl_cnt(k)) begin
                nxt[k]  = ((64'(nv) << 32) | (cnt_m[k] & 64'hFFFF_FFFF)) & CMASK;
                setb[k] = 1'b0;
            end else if (a == 12'h320) begin
                inh_m = nv & (hmask | 32'h5);
            end else if (a[11:5] == 7'h19 && impl_hpm(k)) begin
                evt_m[k] = nv[7:0];
            end else if (a == 12'h7C0) begin
                ovf_n = nv & hmask;
            end else if (a == 12'h7C1) begin
                ovfen_m = nv & hmask;
            end
        end
        ovf_m = ovf_n | setb;
        cnt_m = nxt;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic cyc(input logic r, input logic en, input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic ret, input logic [7:0] ev);
        logic [32:0] m;
        rst = r; csr_en = en; csr_addr = a; csr_op = op; csr_wdata = wd;
        retire = ret; event_in = ev;
        #1;
        m = model_read(a);
        obs_rdata = csr_rdata;
        obs_hit   = csr_hit;
        obs_irq   = ovf_irq;
        check_eq($sformatf("hit_%03h", a), 64'(csr_hit), 64'(!r && en && m[32]));
        check_eq($sformatf("rdata_%03h", a), 64'(csr_rdata), (!r && en && m[32]) ? 64'(m[31:0]) : 64'd0);
        check_eq("ovf_irq", 64'(ovf_irq), 64'(!r && (|(ovf_m & ovfen_m))));
        $display("cyc t=%0t rst=%0b en=%0b addr=%03h op=%0d wd=%08h ret=%0b ev=%02h -> rd=%08h hit=%0b irq=%0b",
                 $time, r, en, a, op, wd, ret, ev, csr_rdata, csr_hit, ovf_irq);
        @(posedge clk);
        model_step(r, en, a, op, wd, ret, ev);
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a, input logic ret);
        cyc(1'b0, 1'b1, a, 2'b00, 32'd0, ret, 8'd0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        cyc(1'b0, 1'b1, a, op, wd, 1'b0, 8'd0);
    endtask

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 11))
            0:       return 12'hB00 + 12'($urandom_range(0, 7));
            1:       return 12'hB80 + 12'($urandom_range(0, 7));
            2:       return 12'h320;
            3:       return 12'h323 + 12'($urandom_range(0, 5));
            4:       return 12'h7C0;
            5:       return 12'h7C1;
            6:       return 12'($urandom);
            7:       return 12'hB83 + 12'($urandom_range(0, 3));
            default: return 12'hB03 + 12'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        logic [11:0] a;
        logic [31:0] wd;
        model_reset();
        rst = 1'b1; csr_en = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
        retire = 1'b0; event_in = '0;
        @(negedge clk);

        // Reset with a write that must be dropped; outputs are 0 while rst is high.
        cyc(1'b1, 1'b1, 12'hB00, 2'b01, 32'h55, 1'b0, 8'd0);
        cyc(1'b1, 1'b1, 12'h7C0, 2'b01, 32'h8, 1'b0, 8'd0);
        check_eq("rst_hit", 64'(obs_hit), 64'd0);

        rd(12'hB00, 1'b0);
        check_eq("mcycle_first", 64'(obs_rdata), 64'd0);
        rd(12'hB00, 1'b0);
        check_eq("mcycle_second", 64'(obs_rdata), 64'd1);
        rd(12'hB02, 1'b0);
        rd(12'hB83, 1'b0);
        rd(12'h320, 1'b0);
        rd(12'h7C0, 1'b0);

        // Event counting with selector 2 (event_in[1]), then inhibit.
        wr(12'h323, 2'b01, 32'd2);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 12'h000, 2'b00, 32'd0, 1'b0, 8'h02);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 12'h000, 2'b00, 32'd0, 1'b0, 8'h01);
        rd(12'hB03, 1'b0);
        check_eq("evt_count5", 64'(obs_rdata), 64'd5);
        wr(12'h320, 2'b10, 32'h8);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 12'h000, 2'b00, 32'd0, 1'b0, 8'h02);
        rd(12'hB03, 1'b0);
        check_eq("evt_inhibited", 64'(obs_rdata), 64'd5);

        // Overflow and interrupt.
        wr(12'h320, 2'b11, 32'h8);
        wr(12'hB83, 2'b01, 32'hFF);
        wr(12'hB03, 2'b01, 32'hFFFF_FFFF);
        wr(12'h7C1, 2'b01, 32'h8);
        cyc(1'b0, 1'b0, 12'h000, 2'b00, 32'd0, 1'b0, 8'h02);
        rd(12'hB03, 1'b0);
        check_eq("ovf_lo", 64'(obs_rdata), 64'd0);
        check_eq("ovf_irq_set", 64'(obs_irq), 64'd1);
        rd(12'hB83, 1'b0);
        check_eq("ovf_hi", 64'(obs_rdata), 64'd0);
        rd(12'h7C0, 1'b0);
        check_eq("ovf_reg", 64'(obs_rdata), 64'h8);
        wr(12'h7C0, 2'b11, 32'h8);
        rd(12'h7C0, 1'b0);
        check_eq("ovf_irq_clr", 64'(obs_irq), 64'd0);

        // Write/increment collision on minstret.
        wr(12'hB02, 2'b01, 32'd10);
        cyc(1'b0, 1'b1, 12'hB02, 2'b01, 32'd100, 1'b1, 8'd0);
        rd(12'hB02, 1'b1);
        check_eq("collide_write_wins", 64'(obs_rdata), 64'd100);
        rd(12'hB02, 1'b0);
        check_eq("collide_next_inc", 64'(obs_rdata), 64'd101);

        // Unimplemented and unowned addresses.
        wr(12'hB10, 2'b01, 32'h1234);
        rd(12'hB10, 1'b0);
        check_eq("unimpl_rdata", 64'(obs_rdata), 64'd0);
        check_eq("unimpl_hit", 64'(obs_hit), 64'd1);
        rd(12'h300, 1'b0);
        check_eq("unowned_hit", 64'(obs_hit), 64'd0);
        check_eq("unowned_rdata", 64'(obs_rdata), 64'd0);

        // Reset in the middle of counting with a simultaneous write.
        wr(12'h7C0, 2'b01, 32'h8);
        wr(12'hB00, 2'b01, 32'd49);
        rd(12'hB00, 1'b0);
        check_eq("pre_rst_mcycle", 64'(obs_rdata), 64'd49);
        cyc(1'b1, 1'b1, 12'hB00, 2'b01, 32'h77, 1'b0, 8'd0);
        rd(12'hB00, 1'b0);
        check_eq("post_rst_mcycle", 64'(obs_rdata), 64'd0);
        rd(12'h7C0, 1'b0);
        check_eq("post_rst_ovf", 64'(obs_rdata), 64'd0);
        rd(12'h323, 1'b0);
        rd(12'hB03, 1'b0);
        rd(12'h7C1, 1'b0);

        // Random CSR traffic with events and retire.
        for (int n = 0; n < 500; n++) begin
            a = rand_addr();
            if (a >= 12'h323 && a <= 12'h33F)
                wd = 32'($urandom_range(0, 10));
            else if (a[11:5] == 7'h5C)
                wd = ($urandom_range(0, 1) != 0) ? 32'hFF : $urandom;
            else if (a[11:5] == 7'h58)
                wd = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            else if (a == 12'h320)
                wd = $urandom & 32'h7F;
            else
                wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            cyc(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0), a,
                2'($urandom_range(0, 3)), wd, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised machine-mode performance-counter bank for the RISC-V core: `mcycle`, `minstret`, `NUM_HPM` programmable event counters with event selectors, `mcountinhibit`, and sticky per-counter overflow with an interrupt request. It sits beside the CSR register file and answers CSR accesses in the counter address ranges. The CSR file muxes `csr_rdata` in when `csr_hit` is high. It generalises fixed 64-bit counters to configurable count, width and event set. It adds inhibit, write/increment collision rules and overflow signalling.

## Interface
- `NUM_HPM`, 4, number of implemented counters `mhpmcounter3..3+NUM_HPM-1`; legal range 1..29.
- `CNT_WIDTH`, 64, implemented bits per counter, including `mcycle` and `minstret`; legal range 33..64.
- `NUM_EVENTS`, 8, width of `event_in`; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `event_in` in NUM_EVENTS: per-cycle event pulses, one count per high cycle.
- `retire` in 1: one instruction retired this cycle.
- `csr_en` in 1: CSR access valid this cycle.
- `csr_addr` in 12: CSR address.
- `csr_op` in 2: `00` read only, `01` write, `10` set, `11` clear.
- `csr_wdata` in 32: operand, already selected from register or zero-extended immediate.
- `csr_rdata` out 32: current value of the addressed CSR.
- `csr_hit` out 1: address is owned by this block.
- `ovf_irq` out 1: `|(mhpmovf & mhpmovfen)`.

## Operation
- **Address map (owned addresses):**
  - `0xB00/0xB80`: `mcycle` low/high.
  - `0xB02/0xB82`: `minstret` low/high.
  - `0xB03+i/0xB83+i`: `mhpmcounter(3+i)` low/high, for i in 0..28.
  - `0x320`: `mcountinhibit`.
  - `0x323+i`: `mhpmevent(3+i)`.
  - `0x7C0`: `mhpmovf`, custom sticky overflow register.
  - `0x7C1`: `mhpmovfen`, custom overflow interrupt enable.
  - `csr_hit` is 1 for all of these addresses while `csr_en` is high, including unimplemented indices.
- **Reads:**
  - `csr_rdata` is 0 when `csr_en` is 0, or when the address is not owned.
  - Unimplemented counter or event indices (3+i ≥ 3+NUM_HPM) read 0 and ignore writes.
  - Counter bits at or above `CNT_WIDTH` read 0.
- **Register field layout:**
  - `mcountinhibit`: bit0 = CY, bit1 hardwired 0, bit2 = IR, bit 3+i = HPM i. Bits for unimplemented counters read 0.
  - `mhpmovf` and `mhpmovfen`: same bit layout, implemented HPM bits only.
  - `mhpmevent`: bits [7:0] stored, bits [31:8] read 0.
- **Write data:**
  - `new = wdata` for op `01`, `cur | wdata` for op `10`, `cur & ~wdata` for op `11`.
  - `cur` is the value read this cycle.
  - Op `00` never writes.
  - Set or clear with `wdata == 0` also writes back `cur`. This has collision significance (see below).
- **Half-word counter writes:**
  - A low-half write replaces bits [31:0] and keeps the high half.
  - A high-half write replaces bits [CNT_WIDTH-1:32] and discards the excess operand bits.
- **Increment conditions (each cycle, from the registered state):**
  - `mcycle` increments when CY = 0.
  - `minstret` increments when `retire` is high and IR = 0.
  - `mhpmcounter(3+i)` increments when HPM i = 0 and `event_in[sel-1]` is high, with 1 ≤ `sel` ≤ NUM_EVENTS.
  - `sel` = 0 or `sel` > NUM_EVENTS never counts.
- **Wrap and overflow:** counters wrap modulo 2^CNT_WIDTH. An HPM counter incrementing from all-ones to 0 sets `mhpmovf` bit 3+i. `mcycle` and `minstret` wrap silently.
- **Collisions:**
  - A write to a counter (either half) in the same cycle as its increment: the write wins and the increment is lost.
  - A write to `mhpmovf` in the same cycle as a hardware overflow set of the same bit: the set wins.
  - A write to `mcountinhibit` or `mhpmevent`: the new value takes effect from the next cycle. Increments in the write cycle use the old value.

## Timing
- **Reset:** on the `clk` edge with `rst` high, all counters, `mhpmevent`, `mcountinhibit`, `mhpmovf` and `mhpmovfen` become 0. Outputs `csr_rdata`, `csr_hit` and `ovf_irq` are 0 while `rst` is high. A CSR access in the reset cycle is discarded.
- **Latency:**
  - `csr_rdata` and `csr_hit` are combinational from `csr_en`, `csr_addr` and register state. No wait states.
  - Writes and increments commit at the next rising edge. A same-cycle read returns the pre-update value.
- **Interrupt:** `ovf_irq` is driven from registers only. It is high from the edge that sets an enabled overflow bit until that bit or its enable is cleared by a CSR write.
- **Access rule:** at most one CSR access per cycle; no handshake.

## Test plan
- **Reset values:** reset, then read `0xB00` on the first cycle after reset → 0. Read it again one cycle later → 1. All other CSRs read 0.
- **Event counting:** write `0x323` = 2, pulse `event_in[1]` for 5 cycles and `event_in[0]` for 3 cycles → `0xB03` reads 5. Set `mcountinhibit` bit3 and pulse 4 more → `0xB03` stays 5.
- **Overflow and interrupt:** `CNT_WIDTH`=40; write `0xB83` = 0xFF, `0xB03` = 0xFFFFFFFF, `0x7C1` = 0x8, then one event → `0xB03`/`0xB83` read 0/0, `0x7C0` = 0x8, `ovf_irq` = 1. Clear `0x7C0` bit3 → `ovf_irq` = 0.
- **Collision:** `minstret` = 10. Write `0xB02` = 100 with `retire` high in the same cycle → reads 100. With `retire` high the following cycle → reads 101.
- **Unimplemented and unowned addresses:** `NUM_HPM`=4; write 0x1234 to `0xB10` → reads 0, `csr_hit` = 1. Access `0x300` → `csr_hit` = 0, `csr_rdata` = 0.
- **Reset mid-count:** while `mcycle` = 50 and `mhpmovf` ≠ 0, assert `rst` for 1 cycle with a simultaneous write to `0xB00` → all CSRs read 0 and the write is dropped.
